// File: rtl/gpio_irq_pkg.sv
// rtl/gpio_irq_pkg.sv - shared constants and helpers for the mmio_gpio_irq block
//
// Purpose: register byte offsets within the 32-byte window, channel width
// limit, debounce history length and byte-strobe helpers.
package gpio_irq_pkg;

  typedef logic [4:0] reg_off_t;

  localparam int NCH_MAX     = 32;
  localparam int DB_HIST_LEN = 3;

  localparam reg_off_t OFF_DIN     = 5'h00;
  localparam reg_off_t OFF_DOUT    = 5'h04;
  localparam reg_off_t OFF_IRQ_EN  = 5'h08;
  localparam reg_off_t OFF_RISE_EN = 5'h0C;
  localparam reg_off_t OFF_FALL_EN = 5'h10;
  localparam reg_off_t OFF_PEND    = 5'h14;
  localparam reg_off_t OFF_LEVEL   = 5'h18;
  localparam reg_off_t OFF_RSVD    = 5'h1C;

  // Replace the strobed bytes of old_val with the matching bytes of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

  // Bit mask covering the strobed bytes.
  function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) m[8*b +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-channel synchroniser, polarity and debounce filter
//
// Purpose: brings NCH asynchronous inputs into the clock domain through a
// 2-flop synchroniser, optionally inverts them, and filters each channel with
// a 3-sample history clocked by the shared i_tick strobe.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   i_tick       : one-cycle sample strobe from the shared prescaler
//   i_raw[NCH]   : asynchronous raw inputs
//   o_db[NCH]    : debounced state after polarity
module gpio_debounce
  import gpio_irq_pkg::*;
#(
  parameter int NCH           = 8,
  parameter int IN_ACTIVE_LOW = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_tick,
  input  logic [NCH-1:0] i_raw,
  output logic [NCH-1:0] o_db
);

  // Synchroniser resets to the idle level so the first post-reset samples
  // look idle rather than active.
  localparam logic [NCH-1:0] IDLE_LVL = (IN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;
  logic [NCH-1:0] w_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= IDLE_LVL;
      r_sync2 <= IDLE_LVL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_in = (IN_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DB_HIST_LEN-1:0] r_hist;
    logic                   r_db;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_hist <= '0;
      end else if (i_tick) begin
        r_hist <= {r_hist[DB_HIST_LEN-2:0], w_in[g]};
      end
    end

    // State follows the history only when every sample agrees.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_db <= 1'b0;
      end else if (&r_hist) begin
        r_db <= 1'b1;
      end else if (~|r_hist) begin
        r_db <= 1'b0;
      end
    end

    assign o_db[g] = r_db;
  end

endmodule

// File: rtl/mmio_gpio_irq.sv
// rtl/mmio_gpio_irq.sv - memory-mapped GPIO with per-channel edge/level interrupts
//
// Purpose: NCH debounced inputs with rise/fall select, enable mask and W1C
// pending bits, NCH output bits, and one registered irq line, on the
// picorv32 native bus with one wait state.
// Optional feature macro: GPIO_IRQ_LEVEL_EN (adds LEVEL register at 0x18).
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   mem_valid/addr/wdata  : bus request, address, write data
//   mem_wstrb             : byte strobes, 0 = read
//   sel_ready, sel_rdata  : one-cycle ack and read data (0 when not ready)
//   gpio_in[NCH]          : asynchronous inputs
//   gpio_out[NCH]         : output register
//   irq                   : registered level interrupt
module mmio_gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int          NCH           = 8,
  parameter logic [31:0] BASE_ADDR     = 32'h0200_5000,
  parameter int          DB_DIV        = 50000,
  parameter int          IN_ACTIVE_LOW = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           mem_valid,
  input  logic [31:0]    mem_addr,
  input  logic [31:0]    mem_wdata,
  input  logic [3:0]     mem_wstrb,
  output logic           sel_ready,
  output logic [31:0]    sel_rdata,
  input  logic [NCH-1:0] gpio_in,
  output logic [NCH-1:0] gpio_out,
  output logic           irq
);

  localparam int             PW       = $clog2(DB_DIV);
  localparam logic [PW-1:0]  PRESC_TC = PW'(DB_DIV - 1);

  // Prescaler
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PRESC_TC);

  always_ff @(posedge clock) begin
    if (reset || w_tick) r_presc <= '0;
    else                 r_presc <= r_presc + 1'b1;
  end

  // Debounced inputs
  logic [NCH-1:0] w_db;

  gpio_debounce #(
    .NCH           (NCH),
    .IN_ACTIVE_LOW (IN_ACTIVE_LOW)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .i_tick (w_tick),
    .i_raw  (gpio_in),
    .o_db   (w_db)
  );

  // Registers
  logic           r_sel_ready;
  logic [31:0]    r_rdata;
  logic [NCH-1:0] r_dout;
  logic [NCH-1:0] r_irq_en;
  logic [NCH-1:0] r_rise_en;
  logic [NCH-1:0] r_fall_en;
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_db_q;
  logic           r_irq;

  // Bus decode: the access is taken on the edge that raises sel_ready.
  logic     w_hit;
  logic     w_acc;
  logic     w_wr;
  reg_off_t w_off;

  assign w_hit = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign w_acc = w_hit && !r_sel_ready;
  assign w_wr  = w_acc && (mem_wstrb != 4'b0000);
  assign w_off = {mem_addr[4:2], 2'b00};

`ifdef GPIO_IRQ_LEVEL_EN
  logic [NCH-1:0] r_level;
`endif

  logic [31:0] w_rd_mux;

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_DIN:     w_rd_mux = 32'(w_db);
      OFF_DOUT:    w_rd_mux = 32'(r_dout);
      OFF_IRQ_EN:  w_rd_mux = 32'(r_irq_en);
      OFF_RISE_EN: w_rd_mux = 32'(r_rise_en);
      OFF_FALL_EN: w_rd_mux = 32'(r_fall_en);
      OFF_PEND:    w_rd_mux = 32'(r_pend);
`ifdef GPIO_IRQ_LEVEL_EN
      OFF_LEVEL:   w_rd_mux = 32'(r_level);
`endif
      default:     w_rd_mux = '0;
    endcase
  end

  // Byte-merged write value for the addressed R/W register; bits >= NCH drop.
  logic [31:0]    w_new;
  logic [31:0]    w_clr32;
  logic [NCH-1:0] w_new_n;
  logic [NCH-1:0] w_clr;

  assign w_new   = merge_bytes(w_rd_mux, mem_wdata, mem_wstrb);
  assign w_clr32 = mem_wdata & strb_mask(mem_wstrb);
  assign w_new_n = w_new[NCH-1:0];
  assign w_clr   = (w_wr && w_off == OFF_PEND) ? w_clr32[NCH-1:0] : '0;

  // Edge detect and pending set
  logic [NCH-1:0] w_rise;
  logic [NCH-1:0] w_fall;
  logic [NCH-1:0] w_set;

  assign w_rise = w_db & ~r_db_q & r_rise_en;
  assign w_fall = ~w_db & r_db_q & r_fall_en;

`ifdef GPIO_IRQ_LEVEL_EN
  // Level channels re-pend every cycle the input is active.
  assign w_set = ((w_rise | w_fall) & ~r_level) | (w_db & r_level);

  always_ff @(posedge clock) begin
    if (reset)                          r_level <= '0;
    else if (w_wr && w_off == OFF_LEVEL) r_level <= w_new_n;
  end
`else
  assign w_set = w_rise | w_fall;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sel_ready <= 1'b0;
      r_rdata     <= '0;
      r_dout      <= '0;
      r_irq_en    <= '0;
      r_rise_en   <= '0;
      r_fall_en   <= '0;
      r_pend      <= '0;
      r_db_q      <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_sel_ready <= w_acc;
      r_rdata     <= (w_acc && mem_wstrb == 4'b0000) ? w_rd_mux : '0;
      if (w_wr && w_off == OFF_DOUT)    r_dout    <= w_new_n;
      if (w_wr && w_off == OFF_IRQ_EN)  r_irq_en  <= w_new_n;
      if (w_wr && w_off == OFF_RISE_EN) r_rise_en <= w_new_n;
      if (w_wr && w_off == OFF_FALL_EN) r_fall_en <= w_new_n;
      // Set is ORed in after the clear so a coincident edge is never lost.
      r_pend      <= (r_pend & ~w_clr) | w_set;
      r_db_q      <= w_db;
      r_irq       <= |(r_pend & r_irq_en);
    end
  end

  logic w_unused;
  assign w_unused = ^{mem_addr[1:0], w_new, w_clr32};

  assign sel_ready = r_sel_ready;
  assign sel_rdata = r_rdata;
  assign gpio_out  = r_dout;
  assign irq       = r_irq;

endmodule

// File: tb/tb_mmio_gpio_irq.sv
// tb/tb_mmio_gpio_irq.sv - self-checking bench for mmio_gpio_irq
module tb_mmio_gpio_irq;
  import gpio_irq_pkg::*;

  localparam int          NCH    = 8;
  localparam logic [31:0] BASE   = 32'h0200_5000;
  localparam int          DB_DIV = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           mem_valid = 1'b0;
  logic [31:0]    mem_addr = '0;
  logic [31:0]    mem_wdata = '0;
  logic [3:0]     mem_wstrb = '0;
  logic           sel_ready;
  logic [31:0]    sel_rdata;
  logic [NCH-1:0] gpio_in = '1;
  logic [NCH-1:0] gpio_out;
  logic           irq;

  mmio_gpio_irq #(
    .NCH(NCH), .BASE_ADDR(BASE), .DB_DIV(DB_DIV), .IN_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .sel_ready(sel_ready),
    .sel_rdata(sel_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [4:0]  off;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // Drives immediately; caller positions time just after a negedge.
  task automatic bus_access(input logic [4:0] off, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] exp_rd,
                            input string nm);
    int n;
    logic [31:0] want;
    mem_valid = 1'b1;
    mem_addr  = BASE | 32'(off);
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    if (wstrb == 4'b0000) exp_q.push_back(exp_rd);
    n = 1;
    @(posedge clock); #1;
    while (!sel_ready && n < 8) begin
      @(posedge clock); #1;
      n++;
    end
    check({nm, " ready latency"}, 32'(n), 32'd1);
    if (wstrb == 4'b0000 && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check({nm, " rdata"}, sel_rdata, want);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    @(posedge clock); #1;
    check({nm, " ready pulse"}, 32'(sel_ready), 32'd0);
    if (wstrb == 4'b0000) check({nm, " rdata idle"}, sel_rdata, 32'd0);
  endtask

  task automatic acc(input logic [4:0] off, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic [31:0] exp_rd,
                     input string nm);
    @(negedge clock);
    bus_access(off, wdata, wstrb, exp_rd, nm);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, kp, c0, c1;
    logic found;

    vecs[0]  = '{OFF_DOUT,    32'h0000_00A5, 4'b0001, 32'h0,  8'hA5};
    vecs[1]  = '{OFF_DOUT,    32'h0,         4'b0000, 32'hA5, 8'hA5};
    vecs[2]  = '{OFF_DOUT,    32'h0000_5A00, 4'b0010, 32'h0,  8'hA5};
    vecs[3]  = '{OFF_DOUT,    32'h0,         4'b0000, 32'hA5, 8'hA5};
    vecs[4]  = '{OFF_DOUT,    32'hFFFF_FF3C, 4'b1111, 32'h0,  8'h3C};
    vecs[5]  = '{OFF_DOUT,    32'h0,         4'b0000, 32'h3C, 8'h3C};
    vecs[6]  = '{OFF_IRQ_EN,  32'h1234_5678, 4'b0001, 32'h0,  8'h3C};
    vecs[7]  = '{OFF_IRQ_EN,  32'h0,         4'b0000, 32'h78, 8'h3C};
    vecs[8]  = '{OFF_IRQ_EN,  32'h0,         4'b1111, 32'h0,  8'h3C};
    vecs[9]  = '{OFF_IRQ_EN,  32'h0,         4'b0000, 32'h0,  8'h3C};
    vecs[10] = '{OFF_RSVD,    32'hFFFF_FFFF, 4'b1111, 32'h0,  8'h3C};
    vecs[11] = '{OFF_RSVD,    32'h0,         4'b0000, 32'h0,  8'h3C};
    vecs[12] = '{OFF_DIN,     32'h0,         4'b0000, 32'h0,  8'h3C};
    vecs[13] = '{OFF_PEND,    32'h0,         4'b0000, 32'h0,  8'h3C};
    vecs[14] = '{OFF_FALL_EN, 32'h0000_00C3, 4'b0011, 32'h0,  8'h3C};
    vecs[15] = '{OFF_FALL_EN, 32'h0,         4'b0000, 32'hC3, 8'h3C};
    vecs[16] = '{OFF_FALL_EN, 32'h0,         4'b1111, 32'h0,  8'h3C};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset sel_ready", 32'(sel_ready), 32'd0);
    check("reset irq",       32'(irq),       32'd0);
    check("reset gpio_out",  32'(gpio_out),  32'd0);
    check("reset rdata",     sel_rdata,      32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Register table
    for (int i = 0; i < 17; i++) begin
      acc(vecs[i].off, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rd, $sformatf("vec%0d", i));
      check($sformatf("vec%0d gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
    end

    // Glitch rejection
    acc(OFF_RISE_EN, 32'h1, 4'b1111, 0, "rise_en");
    acc(OFF_IRQ_EN,  32'h1, 4'b1111, 0, "irq_en");
    @(negedge clock);
    gpio_in[0] = 1'b0;
    wait_cyc(5);
    gpio_in[0] = 1'b1;
    wait_cyc(30);
    check("glitch irq", 32'(irq), 32'd0);
    acc(OFF_DIN,  0, 4'b0000, 32'h0, "glitch din");
    acc(OFF_PEND, 0, 4'b0000, 32'h0, "glitch pend");

    // Press ch0: db within 3*DB_DIV+3 cycles, irq two edges later
    @(negedge clock);
    gpio_in[0] = 1'b0;
    n = 0; found = 1'b0;
    while (n < 40 && !found) begin
      @(posedge clock); #1;
      n++;
      if (irq) found = 1'b1;
    end
    check("press irq seen", 32'(found), 32'd1);
    check("press latency ok", 32'(n <= 3*DB_DIV+5), 32'd1);
    acc(OFF_PEND, 0, 4'b0000, 32'h1, "press pend");
    acc(OFF_DIN,  0, 4'b0000, 32'h1, "press din");

    // W1C clears pend and irq
    acc(OFF_PEND, 32'h1, 4'b0001, 0, "w1c ch0");
    check("w1c irq", 32'(irq), 32'd0);
    acc(OFF_PEND, 0, 4'b0000, 32'h0, "w1c pend");
    @(negedge clock);
    gpio_in[0] = 1'b1;
    wait_cyc(25);
    check("release irq", 32'(irq), 32'd0);
    acc(OFF_PEND, 0, 4'b0000, 32'h0, "release pend");
    acc(OFF_DIN,  0, 4'b0000, 32'h0, "release din");

    // Calibrate ch2 press-to-pend timing
    acc(OFF_RISE_EN, 32'h5, 4'b1111, 0, "rise_en ch2");
    acc(OFF_IRQ_EN,  32'h4, 4'b1111, 0, "irq_en ch2");
    @(negedge clock);
    c0 = cyc;
    gpio_in[2] = 1'b0;
    n = 0; found = 1'b0;
    while (n < 40 && !found) begin
      @(posedge clock); #1;
      n++;
      if (irq) found = 1'b1;
    end
    check("cal irq seen", 32'(found), 32'd1);
    kp = found ? n - 1 : 16;
    acc(OFF_PEND, 0, 4'b0000, 32'h4, "cal pend");
    @(negedge clock);
    gpio_in[2] = 1'b1;
    wait_cyc(25);
    acc(OFF_PEND,   32'h4, 4'b0001, 0, "cal w1c");
    acc(OFF_PEND,   0,     4'b0000, 32'h0, "cal cleared");
    acc(OFF_IRQ_EN, 32'h0, 4'b1111, 0, "mask");

    // Same prescaler phase, W1C lands on the edge that sets pend
    @(negedge clock);
    while ((cyc - c0) % DB_DIV != 0) @(negedge clock);
    c1 = cyc;
    gpio_in[2] = 1'b0;
    while (cyc < c1 + kp - 1) @(negedge clock);
    bus_access(OFF_PEND, 32'h4, 4'b0001, 0, "simul w1c");
    acc(OFF_PEND, 0, 4'b0000, 32'h4, "simul pend");
    check("masked irq", 32'(irq), 32'd0);
    acc(OFF_IRQ_EN, 32'h4, 4'b0001, 0, "unmask");
    check("unmasked irq", 32'(irq), 32'd1);

    // Reset mid-read with pending and DOUT set
    acc(OFF_RISE_EN, 32'hFF, 4'b0001, 0, "rise_en all");
    @(negedge clock);
    gpio_in = '0;
    wait_cyc(25);
    acc(OFF_PEND, 0, 4'b0000, 32'hFF, "all pend");
    check("pre-reset irq", 32'(irq), 32'd1);
    @(negedge clock);
    mem_valid = 1'b1;
    mem_addr  = BASE | 32'(OFF_DIN);
    mem_wstrb = 4'b0000;
    @(posedge clock); #1;
    check("mid-read ready", 32'(sel_ready), 32'd1);
    @(negedge clock);
    reset   = 1'b1;
    gpio_in = '1;
    @(posedge clock); #1;
    check("rst sel_ready", 32'(sel_ready), 32'd0);
    check("rst irq",       32'(irq),       32'd0);
    check("rst gpio_out",  32'(gpio_out),  32'd0);
    check("rst rdata",     sel_rdata,      32'd0);
    mem_valid = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(30);
    check("post-rst irq", 32'(irq), 32'd0);
    acc(OFF_PEND,    0, 4'b0000, 32'h0, "post-rst pend");
    acc(OFF_DOUT,    0, 4'b0000, 32'h0, "post-rst dout");
    acc(OFF_IRQ_EN,  0, 4'b0000, 32'h0, "post-rst irq_en");
    acc(OFF_RISE_EN, 0, 4'b0000, 32'h0, "post-rst rise_en");
    acc(OFF_DIN,     0, 4'b0000, 32'h0, "post-rst din");

`ifdef GPIO_IRQ_LEVEL_EN
    acc(OFF_LEVEL, 32'h1, 4'b0001, 0, "level set");
    acc(OFF_LEVEL, 0, 4'b0000, 32'h1, "level rd");
    @(negedge clock);
    gpio_in[0] = 1'b0;
    wait_cyc(25);
    acc(OFF_PEND, 0,     4'b0000, 32'h1, "level pend");
    acc(OFF_PEND, 32'h1, 4'b0001, 0,     "level w1c held");
    acc(OFF_PEND, 0,     4'b0000, 32'h1, "level repend");
    @(negedge clock);
    gpio_in[0] = 1'b1;
    wait_cyc(25);
    acc(OFF_PEND, 32'h1, 4'b0001, 0,     "level w1c released");
    acc(OFF_PEND, 0,     4'b0000, 32'h0, "level cleared");
`else
    acc(OFF_LEVEL, 32'hFFFF_FFFF, 4'b1111, 0, "level wr");
    acc(OFF_LEVEL, 0, 4'b0000, 32'h0, "level absent");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
